dram: RTL and testbench

Behavioural dual-port DRAM model: 2^ADDR_W words of DATA_W bits, two independent read/write ports (A, B), finite per-word charge retention, and a refresh engine started by a single-cycle request. It is the on-chip scratch memory model for subsystem simulation and for exercising refresh-aware controllers. All logic is synchronous to one clock.

---
 rtl/dram_pkg.sv | 14 +
 rtl/dram_refresh_ctrl.sv | 62 ++++++
 rtl/dram.sv | 98 +++++++++
 tb/tb_dram.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared defaults and types for the dual-port DRAM model and its refresh engine.
package dram_pkg;

  localparam int DRAM_ADDR_W    = 4;
  localparam int DRAM_DATA_W    = 16;
  localparam int DRAM_RETENTION = 1024;
  localparam int DRAM_AGE_W     = $clog2(DRAM_RETENTION);

  typedef enum logic {
    REF_IDLE = 1'b0,
    REF_BUSY = 1'b1
  } ref_state_e;

endpackage

// File: rtl/dram_refresh_ctrl.sv
// Refresh sweep sequencer: one request starts a pass over every row, one row per cycle.
module dram_refresh_ctrl
  import dram_pkg::*;
#(
  parameter int ROW_W = DRAM_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refresh_en_i,
  output logic             refresh_busy_o,
  output logic             row_stb_o,
  output logic [ROW_W-1:0] row_o
);

  localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};

  ref_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REF_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Requests arriving while busy are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      REF_IDLE: begin
        if (refresh_en_i) begin
          state_d = REF_BUSY;
          row_d   = '0;
        end else begin
          state_d = REF_IDLE;
        end
      end
      REF_BUSY: begin
        if (row_q == ROW_LAST) begin
          state_d = REF_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      default: begin
        state_d = REF_IDLE;
        row_d   = '0;
      end
    endcase
  end

  assign refresh_busy_o = (state_q == REF_BUSY);
  assign row_stb_o      = (state_q == REF_BUSY);
  assign row_o          = row_q;

endmodule

// File: rtl/dram.sv
// Behavioural dual-port DRAM: registered reads, per-word retention ageing with decay, row refresh.
module dram
  import dram_pkg::*;
#(
  parameter int ADDR_W           = DRAM_ADDR_W,
  parameter int DATA_W           = DRAM_DATA_W,
  parameter int RETENTION_CYCLES = DRAM_RETENTION
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic              we_b,
  input  logic              enable_a,
  input  logic              enable_b,
  input  logic              refresh_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              refresh_busy
);

  localparam int               DEPTH   = 1 << ADDR_W;
  localparam int               AGE_W   = $clog2(RETENTION_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RETENTION_CYCLES - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AGE_W-1:0]  age_q [DEPTH];
  logic [AGE_W-1:0]  age_d [DEPTH];
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;

  logic              ref_stb_s;
  logic [ADDR_W-1:0] ref_row_s;

  dram_refresh_ctrl #(
    .ROW_W (ADDR_W)
  ) u_refresh (
    .clk            (clk),
    .rst_n          (rst_n),
    .refresh_en_i   (refresh_en),
    .refresh_busy_o (refresh_busy),
    .row_stb_o      (ref_stb_s),
    .row_o          (ref_row_s)
  );

  // Any access (read, write or refresh) restarts a word's retention clock; port A wins write conflicts.
  always_comb begin
    dout_a_d = enable_a ? mem_q[addr_a] : dout_a_q;
    dout_b_d = enable_b ? mem_q[addr_b] : dout_b_q;
    for (int i = 0; i < DEPTH; i++) begin
      logic wa, wb, touch;
      wa    = we_a && (addr_a == ADDR_W'(i));
      wb    = we_b && (addr_b == ADDR_W'(i));
      touch = wa || wb
              || (enable_a && (addr_a == ADDR_W'(i)))
              || (enable_b && (addr_b == ADDR_W'(i)))
              || (ref_stb_s && (ref_row_s == ADDR_W'(i)));
      if (wa) begin
        mem_d[i] = data_in_a;
      end else if (wb) begin
        mem_d[i] = data_in_b;
      end else if (!touch && (age_q[i] == AGE_MAX)) begin
        mem_d[i] = '0;
      end else begin
        mem_d[i] = mem_q[i];
      end
      if (touch) begin
        age_d[i] = '0;
      end else if (age_q[i] == AGE_MAX) begin
        age_d[i] = AGE_MAX;
      end else begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      age_q    <= '{default: '0};
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      mem_q    <= mem_d;
      age_q    <= age_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign data_out_a = dout_a_q;
  assign data_out_b = dout_b_q;

endmodule

// File: tb/tb_dram.sv
// Scoreboard bench for dram: a timestamp-based reference model predicts each cycle's outputs.
module tb_dram;

  localparam int RET = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0, enable_a = 1'b0, enable_b = 1'b0, refresh_en = 1'b0;
  logic [3:0]  addr_a = 4'd0, addr_b = 4'd0;
  logic [15:0] data_in_a = 16'h0, data_in_b = 16'h0;
  logic [15:0] data_out_a, data_out_b;
  logic        refresh_busy;

  dram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_a         (we_a),
    .we_b         (we_b),
    .enable_a     (enable_a),
    .enable_b     (enable_b),
    .refresh_en   (refresh_en),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .data_in_a    (data_in_a),
    .data_in_b    (data_in_b),
    .data_out_a   (data_out_a),
    .data_out_b   (data_out_b),
    .refresh_busy (refresh_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges    = 0;

  // Model: a word's content is valid while fewer than RET+1 edges have passed since its last touch.
  logic [15:0] mem_m [16];
  int          last_m [16];
  bit          busy_m = 1'b0;
  int          row_m = 0;
  logic [15:0] oa_m = 16'h0, ob_m = 16'h0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] eff(input int i, input int t);
    return (t - last_m[i] > RET) ? 16'h0 : mem_m[i];
  endfunction

  task automatic cyc(input logic wa, input logic ea, input logic [3:0] aa, input logic [15:0] da,
                     input logic wb, input logic eb, input logic [3:0] ab, input logic [15:0] db,
                     input logic ren);
    int t;
    logic [15:0] ra, rb;
    exp_t e;
    @(negedge clk);
    we_a = wa; enable_a = ea; addr_a = aa; data_in_a = da;
    we_b = wb; enable_b = eb; addr_b = ab; data_in_b = db;
    refresh_en = ren;
    t  = edges + 1;
    ra = eff(int'(aa), t);
    rb = eff(int'(ab), t);
    if (busy_m) begin
      mem_m[row_m]  = eff(row_m, t);
      last_m[row_m] = t;
      row_m++;
      if (row_m == 16) begin
        busy_m = 1'b0;
        row_m  = 0;
      end
    end else if (ren) begin
      busy_m = 1'b1;
      row_m  = 0;
    end
    if (ea) begin mem_m[aa] = ra; last_m[aa] = t; oa_m = ra; end
    if (eb) begin mem_m[ab] = rb; last_m[ab] = t; ob_m = rb; end
    if (wb) begin mem_m[ab] = db; last_m[ab] = t; end
    if (wa) begin mem_m[aa] = da; last_m[aa] = t; end
    e.a = oa_m; e.b = ob_m; e.busy = busy_m;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int refresh_period);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0,
          (refresh_period > 0) && (k % refresh_period == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    we_a = 1'b0; we_b = 1'b0; enable_a = 1'b0; enable_b = 1'b0; refresh_en = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0;
    busy_m = 1'b0; row_m = 0; oa_m = 16'h0; ob_m = 16'h0;
    #1;
    chk("rst_out_a", data_out_a, 16'h0);
    chk("rst_out_b", data_out_b, 16'h0);
    chk("rst_busy", {15'd0, refresh_busy}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) last_m[i] = edges;
  endtask

  // Monitor: every cycle the driver pushed an expectation for, compare after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data_out_a", data_out_a, e.a);
        chk("data_out_b", data_out_b, e.b);
        chk("refresh_busy", {15'd0, refresh_busy}, {15'd0, e.busy});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0]  wr_addr [8];
  logic [15:0] wr_data [8];

  initial begin
    for (int i = 0; i < 16; i++) begin mem_m[i] = 16'h0; last_m[i] = 0; end
    do_reset();

    // Basic write then read on both ports, then hold with enables low.
    cyc(1'b1, 1'b0, 4'd4, 16'hA5A5, 1'b1, 1'b0, 4'd8, 16'h5A5A, 1'b0);
    cyc(1'b0, 1'b1, 4'd4, 16'h0, 1'b0, 1'b1, 4'd8, 16'h0, 1'b0);
    idle(3, 0);

    // Single refresh pulse, then the write/read-back list.
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    idle(20, 0);
    wr_addr = '{4'd2, 4'd6, 4'd1, 4'd15, 4'd3, 4'd5, 4'd9, 4'd10};
    wr_data = '{16'hFACE, 16'hDEAD, 16'h1111, 16'hFFFF, 16'hDEAD, 16'hBEEF, 16'hAAAA, 16'h5555};
    for (int i = 0; i < 8; i += 2)
      cyc(1'b1, 1'b0, wr_addr[i], wr_data[i], 1'b1, 1'b0, wr_addr[i+1], wr_data[i+1], 1'b0);
    for (int i = 0; i < 8; i += 2)
      cyc(1'b0, 1'b1, wr_addr[i], 16'h0, 1'b0, 1'b1, wr_addr[i+1], 16'h0, 1'b0);

    // Same-address write conflict and cross-port read-before-write.
    cyc(1'b1, 1'b0, 4'd0, 16'h1234, 1'b1, 1'b0, 4'd0, 16'h5678, 1'b0);
    cyc(1'b0, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 16'h1A2B, 1'b0, 1'b1, 4'd0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'd0, 16'h0, 1'b0, 1'b1, 4'd0, 16'h0, 1'b0);

    // Retention: decay when left alone, survival with periodic refresh.
    cyc(1'b1, 1'b0, 4'd7, 16'h3C4D, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    idle(RET, 0);
    cyc(1'b0, 1'b1, 4'd7, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'd7, 16'h3C4D, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    idle(RET, 512);
    cyc(1'b0, 1'b1, 4'd7, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);

    // Held request: back-to-back sweeps.
    idle(40, 1);
    idle(20, 0);

    // Randomized traffic with occasional refresh requests.
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
          ($urandom_range(0, 19) == 0));

    // Reset in the middle of a sweep, then every word must read back zero.
    cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    idle(5, 0);
    do_reset();
    for (int i = 0; i < 16; i += 2)
      cyc(1'b0, 1'b1, 4'(i), 16'h0, 1'b0, 1'b1, 4'(i + 1), 16'h0, 1'b0);
    idle(2, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
